// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared state encoding and constants for the RAM arbiter.
// Provides the arbiter state type and the data word returned on a timed-out read.
package ram_arbiter_pkg;
    typedef enum logic {ARB_IDLE = 1'b0, ARB_WAIT = 1'b1} arb_state_e;
    localparam logic [31:0] TIMEOUT_DATA = 32'h0badf00d;
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// ram_arbiter_rr_pick: combinational round-robin picker.
// Ports: pending_i (one bit per requester), last_grant_i (index served last),
//        grant_idx_o (first pending index after last_grant_i, wrapping), any_pending_o.
module ram_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IW-1:0]      last_grant_i,
    output logic [IW-1:0]      grant_idx_o,
    output logic               any_pending_o
);
    assign any_pending_o = |pending_i;
    // Scan from the farthest candidate down to the nearest so the nearest pending index wins.
    always_comb begin
        grant_idx_o = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (pending_i[(int'(last_grant_i) + k) % NUM_REQ])
                grant_idx_o = IW'((int'(last_grant_i) + k) % NUM_REQ);
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between NUM_REQ pulse-request/ack requesters, round-robin.
// Ports: clk/reset (async, active-high); reqRead/reqWrite/reqAddress/reqData from requesters;
//        rspData/rspReadAck/rspWriteAck back to requesters; ramIn/readAck/writeAck from RAM;
//        ramAddress/ramOut/readReq/writeReq to RAM; error (sticky); debug {state, ramAddress[23:0]}.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      reqRead,
    input  logic [NUM_REQ-1:0]      reqWrite,
    input  logic [32*NUM_REQ-1:0]   reqAddress,
    input  logic [32*NUM_REQ-1:0]   reqData,
    output logic [31:0]             rspData,
    output logic [NUM_REQ-1:0]      rspReadAck,
    output logic [NUM_REQ-1:0]      rspWriteAck,
    input  logic [31:0]             ramIn,
    input  logic                    readAck,
    input  logic                    writeAck,
    output logic [31:0]             ramAddress,
    output logic [31:0]             ramOut,
    output logic                    readReq,
    output logic                    writeReq,
    output logic                    error,
    output logic [31:0]             debug
);
    localparam int IW = $clog2(NUM_REQ);
    arb_state_e state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d, is_read_q, is_read_d, clr;
    logic [NUM_REQ-1:0][31:0] addr_q, addr_d, data_q, data_d;
    logic [IW-1:0] last_grant_q, last_grant_d, grant_q, grant_d, pick;
    logic [7:0] cnt_q, cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d, ram_address_q, ram_address_d, ram_out_q, ram_out_d;
    logic [NUM_REQ-1:0] rsp_read_ack_q, rsp_read_ack_d, rsp_write_ack_q, rsp_write_ack_d;
    logic read_req_q, read_req_d, write_req_q, write_req_d, error_q, error_d;
    logic any_pending, cur_read, hit, expired;

    ram_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .pending_i     (pending_q),
        .last_grant_i  (last_grant_q),
        .grant_idx_o   (pick),
        .any_pending_o (any_pending)
    );

    assign cur_read = is_read_q[grant_q];
    assign hit      = cur_read ? readAck : writeAck;
    assign expired  = cnt_q == 8'(TIMEOUT - 1);

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_d         = grant_q;
        cnt_d           = cnt_q;
        rsp_data_d      = rsp_data_q;
        ram_address_d   = ram_address_q;
        ram_out_d       = ram_out_q;
        error_d         = error_q;
        is_read_d       = is_read_q;
        addr_d          = addr_q;
        data_d          = data_q;
        rsp_read_ack_d  = '0;
        rsp_write_ack_d = '0;
        read_req_d      = 1'b0;
        write_req_d     = 1'b0;
        clr             = '0;
        if (state_q == ARB_IDLE) begin
            if (any_pending) begin
                grant_d       = pick;
                ram_address_d = addr_q[pick];
                ram_out_d     = is_read_q[pick] ? ram_out_q : data_q[pick];
                read_req_d    = is_read_q[pick];
                write_req_d   = !is_read_q[pick];
                cnt_d         = '0;
                state_d       = ARB_WAIT;
            end
        end else if (hit || expired) begin
            // A real ack wins over an expiry landing on the same edge.
            rsp_data_d              = cur_read ? (hit ? ramIn : TIMEOUT_DATA) : rsp_data_q;
            rsp_read_ack_d[grant_q]  = cur_read;
            rsp_write_ack_d[grant_q] = !cur_read;
            clr[grant_q]            = 1'b1;
            last_grant_d            = grant_q;
            error_d                 = error_q | !hit;
            state_d                 = ARB_IDLE;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        // The slot being retired this edge is free again, so a fresh request to it is accepted.
        pending_d = pending_q & ~clr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reqRead[i] || reqWrite[i]) begin
                if (pending_d[i]) begin
                    error_d = 1'b1;
                end else begin
                    pending_d[i] = 1'b1;
                    is_read_d[i] = reqRead[i];
                    addr_d[i]    = reqAddress[32*i +: 32];
                    data_d[i]    = reqData[32*i +: 32];
                end
                if (reqRead[i] && reqWrite[i]) error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ARB_IDLE;
            pending_q       <= '0;
            is_read_q       <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            last_grant_q    <= '0;
            grant_q         <= '0;
            cnt_q           <= '0;
            rsp_data_q      <= '0;
            ram_address_q   <= '0;
            ram_out_q       <= '0;
            rsp_read_ack_q  <= '0;
            rsp_write_ack_q <= '0;
            read_req_q      <= 1'b0;
            write_req_q     <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            is_read_q       <= is_read_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            last_grant_q    <= last_grant_d;
            grant_q         <= grant_d;
            cnt_q           <= cnt_d;
            rsp_data_q      <= rsp_data_d;
            ram_address_q   <= ram_address_d;
            ram_out_q       <= ram_out_d;
            rsp_read_ack_q  <= rsp_read_ack_d;
            rsp_write_ack_q <= rsp_write_ack_d;
            read_req_q      <= read_req_d;
            write_req_q     <= write_req_d;
            error_q         <= error_d;
        end
    end

    assign rspData     = rsp_data_q;
    assign rspReadAck  = rsp_read_ack_q;
    assign rspWriteAck = rsp_write_ack_q;
    assign ramAddress  = ram_address_q;
    assign ramOut      = ram_out_q;
    assign readReq     = read_req_q;
    assign writeReq    = write_req_q;
    assign error       = error_q;
    assign debug       = {7'b0, state_q, ram_address_q[23:0]};
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized self-checking bench for ram_arbiter.
module tb_ram_arbiter;
    logic        clk, reset;
    logic [1:0]  reqRead, reqWrite, rspReadAck, rspWriteAck;
    logic [63:0] reqAddress, reqData;
    logic [31:0] rspData, ramIn, ramAddress, ramOut, debug;
    logic        readAck, writeAck, readReq, writeReq, error;
    int total = 0, bad = 0, rd_pulses = 0;
    logic [31:0] last_rd;

    ram_arbiter #(.NUM_REQ(2), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .reqRead(reqRead), .reqWrite(reqWrite),
        .reqAddress(reqAddress), .reqData(reqData), .rspData(rspData),
        .rspReadAck(rspReadAck), .rspWriteAck(rspWriteAck), .ramIn(ramIn),
        .readAck(readAck), .writeAck(writeAck), .ramAddress(ramAddress), .ramOut(ramOut),
        .readReq(readReq), .writeReq(writeReq), .error(error), .debug(debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) if (readReq) rd_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic issue(input int i, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        reqRead[i] = rd;
        reqWrite[i] = wr;
        reqAddress[32*i +: 32] = a;
        reqData[32*i +: 32] = d;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        reqRead = '0; reqWrite = '0; readAck = 1'b0; writeAck = 1'b0; ramIn = '0;
        tick; tick;
        reset = 1'b0;
        last_rd = '0;
    endtask

    task automatic wait_ram(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (readReq || writeReq) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
    endtask

    // Expects requester g to be granted, acks after dly extra cycles, checks the routed response.
    task automatic serve(input string tag, input int g, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input int dly, input logic [31:0] rv);
        bit ok;
        wait_ram(ok);
        check({tag, ".granted"}, 32'(ok), 32'd1);
        check({tag, ".addr"}, ramAddress, a);
        check({tag, ".kind"}, {30'b0, readReq, writeReq}, rd ? 32'd2 : 32'd1);
        if (!rd) check({tag, ".wdata"}, ramOut, d);
        for (int c = 0; c < dly; c++) begin
            readAck  = rd ? 1'b0 : 1'($urandom % 2);
            writeAck = rd ? 1'($urandom % 2) : 1'b0;
            tick;
            check({tag, ".req_dropped"}, {30'b0, readReq, writeReq}, 32'd0);
            check({tag, ".no_early_rsp"}, {28'b0, rspReadAck, rspWriteAck}, 32'd0);
        end
        readAck  = rd;
        writeAck = !rd;
        ramIn    = rv;
        tick;
        readAck  = 1'b0;
        writeAck = 1'b0;
        if (rd) last_rd = rv;
        check({tag, ".rsp_read_ack"}, 32'(rspReadAck), rd ? 32'(1 << g) : 32'd0);
        check({tag, ".rsp_write_ack"}, 32'(rspWriteAck), rd ? 32'd0 : 32'(1 << g));
        check({tag, ".rsp_data"}, rspData, last_rd);
        tick;
        check({tag, ".ack_one_cycle"}, {28'b0, rspReadAck, rspWriteAck}, 32'd0);
    endtask

    initial begin
        bit ok;
        int base, w, last, n;
        logic [1:0] pend, rd_m;
        logic [31:0] ad[2], dt[2], rv[2];
        reqAddress = '0;
        reqData = '0;
        do_reset;
        reset = 1'b1;
        tick;
        check("reset.rspData", rspData, 32'd0);
        check("reset.acks", {28'b0, rspReadAck, rspWriteAck}, 32'd0);
        check("reset.ramAddress", ramAddress, 32'd0);
        check("reset.ramOut", ramOut, 32'd0);
        check("reset.reqs", {30'b0, readReq, writeReq}, 32'd0);
        check("reset.error", 32'(error), 32'd0);
        check("reset.debug", debug, 32'd0);
        reset = 1'b0;
        tick;

        // Single read
        issue(0, 1, 0, 32'h10, 32'h0);
        tick;
        reqRead = '0;
        check("t1.no_req_yet", 32'(readReq), 32'd0);
        tick;
        check("t1.debug_wait", debug, 32'h0100_0010);
        serve("t1", 0, 1, 32'h10, 32'h0, 1, 32'h12345678);
        check("t1.error", 32'(error), 32'd0);

        // Contention: lastGrant=0 so requester 1 goes first
        base = rd_pulses;
        issue(0, 1, 0, 32'h100, 32'h0);
        issue(1, 1, 0, 32'h200, 32'h0);
        tick;
        reqRead = '0;
        serve("t2a", 1, 1, 32'h200, 32'h0, 0, 32'hAAAA0001);
        serve("t2b", 0, 1, 32'h100, 32'h0, 2, 32'hBBBB0002);
        check("t2.readReq_count", 32'(rd_pulses - base), 32'd2);

        // Write
        issue(1, 0, 1, 32'h40, 32'hCAFEBABE);
        tick;
        reqWrite = '0;
        serve("t3", 1, 0, 32'h40, 32'hCAFEBABE, 1, 32'h0);
        check("t3.error", 32'(error), 32'd0);

        // Timeout: RAM never acks
        issue(0, 1, 0, 32'h80, 32'h0);
        tick;
        reqRead = '0;
        wait_ram(ok);
        check("t4.granted", 32'(ok), 32'd1);
        w = 0;
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (rspReadAck != 0) begin
                w = c;
                break;
            end
        end
        check("t4.cycles", 32'(w), 32'd4);
        check("t4.rsp_read_ack", 32'(rspReadAck), 32'd1);
        check("t4.rsp_data", rspData, 32'h0badf00d);
        check("t4.error", 32'(error), 32'd1);
        tick; tick;
        check("t4.error_sticky", 32'(error), 32'd1);

        // Violation: second pulse while pending
        do_reset;
        check("t5.error_cleared", 32'(error), 32'd0);
        base = rd_pulses;
        issue(0, 1, 0, 32'h20, 32'h0);
        tick;
        issue(0, 1, 0, 32'h24, 32'h0);
        tick;
        reqRead = '0;
        check("t5.error", 32'(error), 32'd1);
        serve("t5", 0, 1, 32'h20, 32'h0, 0, 32'h5555AAAA);
        repeat (5) tick;
        check("t5.one_txn", 32'(rd_pulses - base), 32'd1);
        check("t5.error_sticky", 32'(error), 32'd1);

        // Reset in WAIT, then stray ack
        do_reset;
        issue(0, 1, 0, 32'h30, 32'h0);
        tick;
        reqRead = '0;
        wait_ram(ok);
        check("t6.granted", 32'(ok), 32'd1);
        reset = 1'b1;
        #1;
        check("t6.req_drop_async", 32'(readReq), 32'd0);
        tick;
        reset = 1'b0;
        last_rd = '0;
        readAck = 1'b1;
        ramIn = 32'hDEADBEEF;
        tick;
        readAck = 1'b0;
        check("t6.no_rsp", 32'(rspReadAck), 32'd0);
        check("t6.rspData", rspData, 32'd0);
        check("t6.ramAddress", ramAddress, 32'd0);
        check("t6.error", 32'(error), 32'd0);
        tick;
        check("t6.still_idle", {30'b0, readReq, writeReq}, 32'd0);
        issue(1, 1, 0, 32'h300, 32'h0);
        tick;
        reqRead = '0;
        serve("t6n", 1, 1, 32'h300, 32'h0, 1, 32'h0600_0006);

        // Randomized rounds checked against a round-robin reference
        do_reset;
        last = 0;
        for (int r = 0; r < 30; r++) begin
            pend = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                rd_m[i] = 1'($urandom % 2);
                ad[i] = $urandom;
                dt[i] = $urandom;
                rv[i] = $urandom;
                if (pend[i]) issue(i, rd_m[i], !rd_m[i], ad[i], dt[i]);
            end
            tick;
            reqRead = '0;
            reqWrite = '0;
            while (pend != 0) begin
                n = -1;
                for (int k = 1; k <= 2 && n < 0; k++)
                    if (pend[(last + k) % 2]) n = (last + k) % 2;
                serve($sformatf("rnd%0d", r), n, rd_m[n], ad[n], dt[n], int'($urandom_range(0, 2)), rv[n]);
                pend[n] = 1'b0;
                last = n;
            end
        end
        check("rnd.error", 32'(error), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
